dsp_add: RTL and testbench



---
 rtl/dsp_add.sv | 182 ++++++++++++++++++
 tb/tb_dsp_add.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dsp_add.sv
// dsp_add / dsp_add_v2: registered adders modelled on one DSP48E2 slice with
// the ALU in add mode. dsp_add runs the slice as a single 48-bit lane
// (USE_SIMD = ONE48). dsp_add_v2 splits it into two 24-bit lanes with no
// carry between them (USE_SIMD = TWO24). Only the P register is used, and
// RSTP is the only reset.

// Behavioural model of the DSP48E2 datapath used by both adders:
// X/Y/Z/W multiplexers, the SIMD-aware ALU adder and the P register.
module dsp_add_core #(
  parameter int unsigned W     = 48,
  parameter bit          TWO24 = 1'b0,
  localparam int unsigned OUT_W = TWO24 ? 2 * W : W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [29:0]      i_a,
  input  logic [17:0]      i_b,
  input  logic [47:0]      i_c,
  output logic [OUT_W-1:0] o_p
);

  // OPMODE = W:0, Z:C, Y:0, X:A:B, giving P = C + A:B.
  localparam logic [8:0] OPMODE  = 9'b00_011_00_11;
  localparam logic [3:0] ALUMODE = 4'b0000;

  logic [47:0] r_p;
  logic [47:0] w_m;
  logic [47:0] w_x;
  logic [47:0] w_y;
  logic [47:0] w_z;
  logic [47:0] w_w;
  logic [47:0] w_alu;
  logic        w_cin;
  logic [25:0] w_sum_lo;
  logic [1:0]  w_carry_lo;
  logic [23:0] w_sum_hi;

  // The multiplier is unused and CARRYIN is tied low.
  assign w_m   = '0;
  assign w_cin = 1'b0;

  // Decode OPMODE into the four ALU input multiplexers.
  always_comb begin
    w_x = '0;
    w_y = '0;
    w_z = '0;
    w_w = '0;
    case (OPMODE[1:0])
      2'b01:   w_x = w_m;
      2'b10:   w_x = r_p;
      2'b11:   w_x = {i_a, i_b};
      default: w_x = '0;
    endcase
    case (OPMODE[3:2])
      2'b01:   w_y = w_m;
      2'b10:   w_y = '1;
      2'b11:   w_y = i_c;
      default: w_y = '0;
    endcase
    case (OPMODE[6:4])
      3'b010:  w_z = r_p;
      3'b011:  w_z = i_c;
      default: w_z = '0;
    endcase
    case (OPMODE[8:7])
      2'b01:   w_w = r_p;
      2'b11:   w_w = i_c;
      default: w_w = '0;
    endcase
  end

  // Split the adder at bit 24. In TWO24 mode the low-lane carry is dropped,
  // so the lanes are independent. In ONE48 mode it carries into the high half.
  assign w_sum_lo   = 26'(w_x[23:0]) + 26'(w_y[23:0]) + 26'(w_z[23:0])
                    + 26'(w_w[23:0]) + 26'(w_cin);
  assign w_carry_lo = w_sum_lo[25:24];
  assign w_sum_hi   = w_x[47:24] + w_y[47:24] + w_z[47:24] + w_w[47:24]
                    + (TWO24 ? 24'd0 : 24'(w_carry_lo));

  // Only the ALUMODE add function is modelled. The carry-out of the top
  // lane is discarded.
  always_comb begin
    w_alu = '0;
    case (ALUMODE)
      4'b0000: w_alu = {w_sum_hi, w_sum_lo[23:0]};
      default: w_alu = '0;
    endcase
  end

  // P register: synchronous active-low RSTP, with the clock enable tied high.
  always_ff @(posedge clock) begin
    if (!reset) r_p <= '0;
    else        r_p <= w_alu;
  end

  // Expose only the low W bits of each active lane.
  if (TWO24) begin : g_two24_out
    assign o_p = {r_p[24 +: W], r_p[0 +: W]};
  end else begin : g_one48_out
    assign o_p = r_p[W-1:0];
  end

endmodule

// Single-lane registered adder: y = (a + b) mod 2^width, with one cycle of latency.
module dsp_add #(
  parameter int unsigned width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] y
);

  if (width == 0 || width > 48) begin : g_bad_width
    $error("dsp_add: width must be in 1..48");
  end

  logic [47:0] w_ab;
  logic [47:0] w_c;

  // a drives A:B on X and b drives C on Z, both zero-extended to 48 bits.
  assign w_ab = 48'(a);
  assign w_c  = 48'(b);

  dsp_add_core #(
    .W     (width),
    .TWO24 (1'b0)
  ) u_dsp (
    .clock (clock),
    .reset (reset),
    .i_a   (w_ab[47:18]),
    .i_b   (w_ab[17:0]),
    .i_c   (w_c),
    .o_p   (y)
  );

endmodule

// Dual-lane registered adder. Each lane computes (a + b) mod 2^width on its own.
module dsp_add_v2 #(
  parameter int unsigned width = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] a0,
  input  logic [width-1:0] b0,
  input  logic [width-1:0] a1,
  input  logic [width-1:0] b1,
  output logic [width-1:0] y0,
  output logic [width-1:0] y1
);

  if (width == 0 || width > 24) begin : g_bad_width
    $error("dsp_add_v2: width must be in 1..24");
  end

  logic [47:0]        w_ab;
  logic [47:0]        w_c;
  logic [2*width-1:0] w_p;

  // Lane 0 occupies bits 23:0 and lane 1 occupies bits 47:24.
  assign w_ab = {24'(a1), 24'(a0)};
  assign w_c  = {24'(b1), 24'(b0)};

  dsp_add_core #(
    .W     (width),
    .TWO24 (1'b1)
  ) u_dsp (
    .clock (clock),
    .reset (reset),
    .i_a   (w_ab[47:18]),
    .i_b   (w_ab[17:0]),
    .i_c   (w_c),
    .o_p   (w_p)
  );

  assign y0 = w_p[width-1:0];
  assign y1 = w_p[2*width-1:width];

endmodule

// File: tb/tb_dsp_add.sv
// Testbench for dsp_add at widths 8/32/48 and for dsp_add_v2 at width 24.
module tb_dsp_add;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [7:0]  a8,  b8,  y8;
  logic [31:0] a32, b32, y32;
  logic [47:0] a48, b48, y48;
  logic [23:0] a0, b0, a1, b1, y0, y1;

  dsp_add #(.width(8)) u_add8 (
    .clock(clock), .reset(reset), .a(a8), .b(b8), .y(y8));
  dsp_add #(.width(32)) u_add32 (
    .clock(clock), .reset(reset), .a(a32), .b(b32), .y(y32));
  dsp_add #(.width(48)) u_add48 (
    .clock(clock), .reset(reset), .a(a48), .b(b48), .y(y48));
  dsp_add_v2 #(.width(24)) u_add_v2 (
    .clock(clock), .reset(reset),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .y0(y0), .y1(y1));

  typedef struct packed {
    logic [7:0]  a8,  b8,  e8;
    logic [31:0] a32, b32, e32;
    logic [47:0] a48, b48, e48;
    logic [23:0] a0, b0, a1, b1, e0, e1;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input vec_t v);
    a8 = v.a8;   b8 = v.b8;
    a32 = v.a32; b32 = v.b32;
    a48 = v.a48; b48 = v.b48;
    a0 = v.a0;   b0 = v.b0;
    a1 = v.a1;   b1 = v.b1;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, ".y8"},  48'(y8),  48'(v.e8));
    chk({tag, ".y32"}, 48'(y32), 48'(v.e32));
    chk({tag, ".y48"}, y48,      v.e48);
    chk({tag, ".y0"},  48'(y0),  48'(v.e0));
    chk({tag, ".y1"},  48'(y1),  48'(v.e1));
  endtask

  // Reference: modular addition at the given width.
  function automatic longint unsigned ref_add(input longint unsigned a,
                                              input longint unsigned b,
                                              input int unsigned w);
    return (a + b) % (64'd1 << w);
  endfunction

  function automatic logic [47:0] pick(input logic [47:0] rnd, input int unsigned w);
    logic [47:0] ones;
    ones = '1;
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return ones >> (48 - w);
      default: return rnd;
    endcase
  endfunction

  vec_t tbl[4];
  vec_t q[$];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{a8: 8'hFF, b8: 8'h10, e8: 8'h0F,
               a32: 32'h00000001, b32: 32'hFFFF0001, e32: 32'hFFFF0002,
               a48: 48'hFFFFFFFFFFFF, b48: 48'h1, e48: 48'h0,
               a0: 24'hFFFFFF, b0: 24'h000010, a1: 24'd23, b1: 24'd7,
               e0: 24'h00000F, e1: 24'd30};
    tbl[1] = '{a8: 8'h80, b8: 8'h80, e8: 8'h00,
               a32: 32'hFFFFFFFF, b32: 32'hFFFFFFFF, e32: 32'hFFFFFFFE,
               a48: 48'h800000000000, b48: 48'h7FFFFFFFFFFF, e48: 48'hFFFFFFFFFFFF,
               a0: 24'hFFFFFF, b0: 24'h000001, a1: 24'h0, b1: 24'h0,
               e0: 24'h0, e1: 24'h0};
    tbl[2] = '{a8: 8'h12, b8: 8'h34, e8: 8'h46,
               a32: 32'h12345678, b32: 32'h11111111, e32: 32'h23456789,
               a48: 48'h123456789ABC, b48: 48'h111111111111, e48: 48'h23456789ABCD,
               a0: 24'h7FFFFF, b0: 24'h000001, a1: 24'hFFFFFF, b1: 24'hFFFFFF,
               e0: 24'h800000, e1: 24'hFFFFFE};
    tbl[3] = '{a8: 8'hFE, b8: 8'h03, e8: 8'h01,
               a32: 32'h0, b32: 32'h0, e32: 32'h0,
               a48: 48'h0, b48: 48'hFFFFFFFFFFFF, e48: 48'hFFFFFFFFFFFF,
               a0: 24'h0, b0: 24'h0, a1: 24'h800000, b1: 24'h800000,
               e0: 24'h0, e1: 24'h0};

    // Reset dominates non-zero inputs.
    reset = 1'b0;
    drive(tbl[0]);
    tick;
    tick;
    chk("rst.y8",  48'(y8),  48'h0);
    chk("rst.y32", 48'(y32), 48'h0);
    chk("rst.y48", y48,      48'h0);
    chk("rst.y0",  48'(y0),  48'h0);
    chk("rst.y1",  48'(y1),  48'h0);

    // The first edge after release captures the current inputs.
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i]);
      tick;
      check_vec($sformatf("tbl%0d", i), tbl[i]);
    end

    // Reset in mid-operation with steady inputs giving 5.
    a8 = 8'd2; b8 = 8'd3;
    a0 = 24'd1; b0 = 24'd4; a1 = 24'd2; b1 = 24'd3;
    tick;
    chk("mid.pre.y8", 48'(y8), 48'd5);
    reset = 1'b0;
    tick;
    chk("mid.rst.y8", 48'(y8), 48'd0);
    chk("mid.rst.y0", 48'(y0), 48'd0);
    chk("mid.rst.y1", 48'(y1), 48'd0);
    reset = 1'b1;
    tick;
    chk("mid.rel.y8", 48'(y8), 48'd5);
    chk("mid.rel.y0", 48'(y0), 48'd5);
    chk("mid.rel.y1", 48'(y1), 48'd5);

    // Back-to-back random stream checked against the modular-sum model.
    for (int n = 0; n < 60; n++) begin
      vec_t v;
      vec_t e;
      v.a8  = 8'(pick(48'($urandom()), 8));
      v.b8  = 8'(pick(48'($urandom()), 8));
      v.a32 = 32'(pick(48'($urandom()), 32));
      v.b32 = 32'(pick(48'($urandom()), 32));
      v.a48 = pick(48'({$urandom(), $urandom()}), 48);
      v.b48 = pick(48'({$urandom(), $urandom()}), 48);
      v.a0  = 24'(pick(48'($urandom()), 24));
      v.b0  = 24'(pick(48'($urandom()), 24));
      v.a1  = 24'(pick(48'($urandom()), 24));
      v.b1  = 24'(pick(48'($urandom()), 24));
      v.e8  = 8'(ref_add(64'(v.a8), 64'(v.b8), 8));
      v.e32 = 32'(ref_add(64'(v.a32), 64'(v.b32), 32));
      v.e48 = 48'(ref_add(64'(v.a48), 64'(v.b48), 48));
      v.e0  = 24'(ref_add(64'(v.a0), 64'(v.b0), 24));
      v.e1  = 24'(ref_add(64'(v.a1), 64'(v.b1), 24));
      drive(v);
      q.push_back(v);
      tick;
      if (q.size() == 0) begin
        chk("stream.queue", 48'd0, 48'd1);
      end else begin
        e = q.pop_front();
        check_vec($sformatf("rnd%0d", n), e);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
